// File: rtl/mem_pkg.sv
// Defaults and shared types for the unified instruction/data memory.
package mem_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DEPTH     = 256;
  localparam int DEF_DATA_BASE = 128;

  // Which requester owns the single array port this cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_I    = 2'd1,
    SEL_D    = 2'd2
  } port_sel_e;

endpackage

// File: rtl/mem_arb.sv
// Data-first arbiter for the shared array port. A streak counter caps how
// many data grants in a row may be given while a fetch is waiting.
module mem_arb
  import mem_pkg::*;
#(
  parameter int MAX_D_STREAK = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_req,
  input  logic      d_req,
  output logic      i_gnt,
  output logic      d_gnt,
  output port_sel_e sel
);

  localparam logic [2:0] STREAK_MAX = 3'(MAX_D_STREAK);

  logic [2:0] streak_q;
  logic [2:0] streak_d;

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    sel = SEL_NONE;
    if (!rst_n) begin
      sel = SEL_NONE;
    end else if (i_req && d_req) begin
      sel = (streak_q >= STREAK_MAX) ? SEL_I : SEL_D;
    end else if (d_req) begin
      sel = SEL_D;
    end else if (i_req) begin
      sel = SEL_I;
    end
  end

  assign i_gnt = (sel == SEL_I);
  assign d_gnt = (sel == SEL_D);

  // Streak counts data grants that overtook a waiting fetch.
  always_comb begin
    streak_d = streak_q;
    if (!i_req || i_gnt) begin
      streak_d = 3'd0;
    end else if (d_gnt && (streak_q < STREAK_MAX)) begin
      streak_d = streak_q + 3'd1;
    end
  end

  // Streak register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= 3'd0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/unified_mem_arb.sv
// Unified memory shared by fetch and load/store ports. Data accesses are
// offset into the upper data region and faulted when they fall past its end.
module unified_mem_arb
  import mem_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int DATA_BASE    = DEF_DATA_BASE,
  parameter int MAX_D_STREAK = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_fault
);

  localparam logic [ADDR_W:0]   D_WORDS  = (ADDR_W+1)'(DEPTH - DATA_BASE);
  localparam logic [ADDR_W-1:0] BASE_OFS = ADDR_W'(DATA_BASE);

  port_sel_e sel;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  logic              d_legal;
  logic [ADDR_W-1:0] d_phys;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;

  logic              i_rvalid_q;
  logic              d_rvalid_q;
  logic              d_fault_q;
  logic [DATA_W-1:0] i_hold_q;
  logic [DATA_W-1:0] d_hold_q;

  mem_arb #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .i_req(i_req),
    .d_req(d_req),
    .i_gnt(i_gnt),
    .d_gnt(d_gnt),
    .sel  (sel)
  );

  // Relocate data offsets; the range check is done before the add so an
  // overflowing offset can never alias into the instruction region.
  always_comb begin
    d_legal  = ({1'b0, d_addr} < D_WORDS);
    d_phys   = d_addr + BASE_OFS;
    mem_addr = (sel == SEL_I) ? i_addr : d_phys;
    mem_we   = d_gnt && d_we && d_legal;
    mem_re   = i_gnt || (d_gnt && !d_we && d_legal);
  end

  // Single-port array with registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= d_wdata;
    end
    if (mem_re) begin
      rd_q <= mem[mem_addr];
    end
  end

  // Response strobes: one-cycle pulses following the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_fault_q  <= 1'b0;
    end else begin
      i_rvalid_q <= i_gnt;
      d_rvalid_q <= d_gnt && (!d_we || !d_legal);
      d_fault_q  <= d_gnt && !d_legal;
    end
  end

  // Remember the last presented read data so outputs hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      if (i_rvalid_q) begin
        i_hold_q <= i_rdata;
      end
      if (d_rvalid_q) begin
        d_hold_q <= d_rdata;
      end
    end
  end

  // Output data: live array data on a response cycle, held value otherwise.
  always_comb begin
    i_rdata = i_rvalid_q ? rd_q : i_hold_q;
    if (d_rvalid_q) begin
      d_rdata = d_fault_q ? '0 : rd_q;
    end else begin
      d_rdata = d_hold_q;
    end
  end

  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign d_fault  = d_fault_q;

endmodule

// File: tb/tb_unified_mem_arb.sv
// Bench for unified_mem_arb: directed scenarios plus randomized traffic
// checked against a word-array reference model of the memory and arbiter.
module tb_unified_mem_arb;

  localparam int MAXS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_req;
  logic [7:0] i_addr;
  logic       i_gnt;
  logic       i_rvalid;
  logic [7:0] i_rdata;
  logic       d_req;
  logic       d_we;
  logic [7:0] d_addr;
  logic [7:0] d_wdata;
  logic       d_gnt;
  logic       d_rvalid;
  logic [7:0] d_rdata;
  logic       d_fault;

  unified_mem_arb #(.MAX_D_STREAK(MAXS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_gnt   (i_gnt),
    .i_rvalid(i_rvalid),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_gnt   (d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata (d_rdata),
    .d_fault (d_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] mem_m [256];
  bit         mem_k [256];
  int         run;            // data grants given in a row while a fetch waits
  logic [7:0] ei_data;
  bit         ei_known;
  logic [7:0] ed_data;
  bit         ed_known;
  logic       dut_dgnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run      = 0;
    ei_data  = 8'h00;
    ei_known = 1'b1;
    ed_data  = 8'h00;
    ed_known = 1'b1;
  endtask

  // One bus cycle: drive at negedge, check grants, check responses after posedge.
  task automatic cycle(input bit ir, input logic [7:0] ia, input bit dr, input bit dw,
                       input logic [7:0] da, input logic [7:0] dwd,
                       output bit gi, output bit gd);
    bit mi, md, e_irv, e_drv, e_df;
    int phys;
    @(negedge clk);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    #1;
    md = dr && !(ir && run >= MAXS);
    mi = ir && !md;
    dut_dgnt = d_gnt;
    chk("i_gnt", i_gnt, mi);
    chk("d_gnt", d_gnt, md);
    chk("one_gnt", i_gnt & d_gnt, 1'b0);
    if (!ir || mi) run = 0;
    else if (md && run < MAXS) run++;
    e_irv = mi; e_drv = 0; e_df = 0;
    if (mi) begin
      ei_known = mem_k[ia];
      ei_data  = mem_m[ia];
    end
    if (md) begin
      phys = 128 + int'(da);
      if (da >= 8'd128) begin
        e_drv = 1; e_df = 1; ed_data = 8'h00; ed_known = 1;
      end else if (dw) begin
        mem_m[phys] = dwd; mem_k[phys] = 1;
      end else begin
        e_drv = 1; ed_data = mem_m[phys]; ed_known = mem_k[phys];
      end
    end
    @(posedge clk);
    #1;
    chk("i_rvalid", i_rvalid, e_irv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("d_fault", d_fault, e_df);
    if (ei_known) chk("i_rdata", i_rdata, ei_data);
    if (ed_known) chk("d_rdata", d_rdata, ed_data);
    $display("cyc ireq=%0b ia=%0d dreq=%0b we=%0b da=%0d gnt=%0b%0b irv=%0b ird=%02h drv=%0b df=%0b drd=%02h",
             ir, ia, dr, dw, da, mi, md, i_rvalid, i_rdata, d_rvalid, d_fault, d_rdata);
    gi = mi; gd = md;
  endtask

  bit         gi, gd;
  logic [7:0] snap;
  bit         pat [6];

  // Pending requests for the randomized phase
  bit         pi_v, pd_v, pd_we;
  logic [7:0] pi_a, pd_a, pd_wd;

  initial begin
    for (int k = 0; k < 256; k++) begin mem_m[k] = 8'h00; mem_k[k] = 0; end
    model_reset();
    pat = '{1, 1, 0, 1, 1, 0};

    // Reset with both requests high: no grants, all outputs zero
    rst_n = 0; i_req = 1; i_addr = 8'd3; d_req = 1; d_we = 0; d_addr = 8'd1; d_wdata = 8'h00;
    #3;
    chk("rst_i_gnt", i_gnt, 1'b0);
    chk("rst_d_gnt", d_gnt, 1'b0);
    chk("rst_i_rvalid", i_rvalid, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    chk("rst_d_fault", d_fault, 1'b0);
    chk("rst_i_rdata", i_rdata, 8'h00);
    chk("rst_d_rdata", d_rdata, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1; i_req = 0; d_req = 0;

    // Fill the data region so every legal load has a known answer
    for (int k = 0; k < 128; k++) cycle(0, 8'd0, 1, 1, 8'(k), 8'($urandom), gi, gd);

    // Store then load d_addr 5
    cycle(0, 8'd0, 1, 1, 8'd5, 8'hA5, gi, gd);
    cycle(0, 8'd0, 1, 0, 8'd5, 8'h00, gi, gd);
    chk("ld5_data", d_rdata, 8'hA5);
    chk("ld5_fault", d_fault, 1'b0);

    // Unified view: fetch of physical 133
    cycle(1, 8'd133, 0, 0, 8'd0, 8'h00, gi, gd);
    chk("if133_data", i_rdata, 8'hA5);

    // Both requesting continuously
    cycle(0, 8'd0, 0, 0, 8'd0, 8'h00, gi, gd);
    for (int k = 0; k < 6; k++) begin
      cycle(1, 8'd130, 1, 0, 8'(k), 8'h00, gi, gd);
      chk("pattern_d", dut_dgnt, pat[k]);
    end

    // Faulting store must not alias onto physical 0
    cycle(1, 8'd0, 0, 0, 8'd0, 8'h00, gi, gd);
    snap = i_rdata;
    cycle(0, 8'd0, 1, 1, 8'd128, ~snap, gi, gd);
    chk("fst_fault", d_fault, 1'b1);
    chk("fst_rdata", d_rdata, 8'h00);
    cycle(1, 8'd0, 0, 0, 8'd0, 8'h00, gi, gd);
    chk("fst_nowrap", i_rdata, snap);

    // Last legal data word
    cycle(0, 8'd0, 1, 1, 8'd127, 8'h3C, gi, gd);
    cycle(0, 8'd0, 1, 0, 8'd127, 8'h00, gi, gd);
    chk("ld127_data", d_rdata, 8'h3C);
    chk("ld127_fault", d_fault, 1'b0);

    // Reset asserted right after a load grant drops the response
    @(negedge clk);
    i_req = 0; d_req = 1; d_we = 0; d_addr = 8'd5;
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid_d_rvalid", d_rvalid, 1'b0);
    chk("mid_d_fault", d_fault, 1'b0);
    chk("mid_d_rdata", d_rdata, 8'h00);
    chk("mid_i_rdata", i_rdata, 8'h00);
    chk("mid_d_gnt", d_gnt, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1; d_req = 0;
    cycle(1, 8'd133, 0, 0, 8'd0, 8'h00, gi, gd);
    chk("post_rst_133", i_rdata, 8'hA5);

    // Randomized traffic with hold-until-grant and occasional cancels
    pi_v = 0; pd_v = 0; pd_we = 0; pi_a = 0; pd_a = 0; pd_wd = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!pi_v && ($urandom % 4 != 0)) begin pi_v = 1; pi_a = 8'($urandom); end
      else if (pi_v && ($urandom % 16 == 0)) pi_v = 0;
      if (!pd_v && ($urandom % 4 != 0)) begin
        pd_v = 1; pd_we = 1'($urandom); pd_a = 8'($urandom_range(0, 159)); pd_wd = 8'($urandom);
      end else if (pd_v && ($urandom % 16 == 0)) pd_v = 0;
      cycle(pi_v, pi_a, pd_v, pd_we, pd_a, pd_wd, gi, gd);
      if (gi) pi_v = 0;
      if (gd) pd_v = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/unified_mem_arb.md
Name: unified_mem_arb

Overview:
- Next-generation unified (von Neumann) memory for the pipelined core.
- A single-ported storage array is shared by an instruction-fetch port and a data load/store port.
- Per-port req/gnt handshake with a registered read response (1-cycle latency).
- Data-first arbitration with an anti-starvation guard; data accesses are relocated into, and bounds-checked against, the data region.

Parameters:
- DATA_W, 8, word width of each memory location.
- ADDR_W, 8, address width of both ports.
- DEPTH, 256, number of words; must equal 2**ADDR_W.
- DATA_BASE, 128, first physical word of the data region; the instruction region is 0..DATA_BASE-1.
- MAX_D_STREAK, 2, consecutive data grants allowed while a fetch waits; range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request.
- i_addr  in  ADDR_W  fetch physical address.
- i_gnt  out  1  fetch accepted this cycle (combinational).
- i_rvalid  out  1  i_rdata valid (registered).
- i_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data-region offset.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access accepted this cycle (combinational).
- d_rvalid  out  1  load data or fault response valid (registered).
- d_rdata  out  DATA_W  loaded word.
- d_fault  out  1  out-of-region data access (registered, pulses with d_rvalid).

Behaviour:
- Reset (rst_n low, asynchronous):
  - i_rvalid, d_rvalid, d_fault = 0; i_rdata, d_rdata = 0; streak counter = 0.
  - Array contents are not reset.
  - The gnt outputs are forced to 0 while rst_n is low.
- Single array port: at most one grant per cycle; i_gnt and d_gnt are never both 1.
- Arbitration (combinational from req and streak):
  - Only one requester: it is granted.
  - Both requesting: d_gnt, unless streak == MAX_D_STREAK, in which case i_gnt.
  - Streak counter: increments on d_gnt while i_req = 1; clears on i_gnt or when i_req = 0; saturates at MAX_D_STREAK.
- A requester holds its req and its address/data stable until it sees gnt. Dropping req before gnt is legal and is treated as a cancel.
- Data address mapping:
  - phys = DATA_BASE + d_addr.
  - Legal only when d_addr < DEPTH - DATA_BASE. Otherwise the access is a fault.
  - A faulting access is still granted. Nothing is written, and no wrap-around write into the instruction region ever occurs.
- Store:
  - Granted with d_we = 1 and legal: Mem[phys] <= d_wdata at that clk edge.
  - No d_rvalid for a legal store.
  - A faulting store: d_rvalid = 1 and d_fault = 1 on the next cycle.
- Load:
  - Granted with d_we = 0: on the next cycle d_rvalid = 1 and d_rdata = Mem[phys].
  - If faulting: d_rdata = 0 and d_fault = 1.
- Fetch:
  - Granted: on the next cycle i_rvalid = 1 and i_rdata = Mem[i_addr]. Any address is legal.
  - Fetch may read the data region (unified memory).
- Back-to-back: a new grant is allowed every cycle; throughput is 1 access/cycle total.
- Read-after-write: a load or fetch granted the cycle after a store to the same word returns the new value, since the write has already committed.
- i_rdata and d_rdata hold their last value while rvalid = 0. rvalid and d_fault are 1-cycle pulses.
- Reset mid-access: any pending response is dropped (rvalid = 0). A store granted in the cycle reset asserts is not guaranteed to commit.

Decomposition:
- Shared package mem_pkg:
  - DATA_W, ADDR_W, DEPTH, DATA_BASE defaults.
  - Port-select enum {SEL_NONE, SEL_I, SEL_D}.
- Sub-module mem_arb: the grant logic plus the streak counter.
- The array, address mapping and response registers stay in the top module.

Test Plan:
- Reset, then store d_addr=5 data 0xA5; next cycle load d_addr=5 -> d_rvalid one cycle later, d_rdata=0xA5, d_fault=0.
- Fetch i_addr=133 after that store -> i_rvalid next cycle with i_rdata=0xA5 (unified view: 128+5).
- d_req and i_req held high continuously (MAX_D_STREAK=2) -> grant pattern D,D,I,D,D,I; never both gnt high.
- Store d_addr=128 (phys 256 is out of range) with data 0xFF -> d_rvalid=1, d_fault=1, d_rdata=0; then fetch i_addr=0 is unchanged.
- Load d_addr=127 -> legal: Mem[255] returned with d_fault=0.
- Assert rst_n low the cycle after a load grant -> d_rvalid stays 0, all outputs 0; array word written earlier still reads 0xA5 after reset.
